// File: rtl/en_pulse_gen_pkg.sv
// Shared types and defaults for the enable-strobe generator.
package en_pulse_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_e;
endpackage

// File: rtl/en_pulse_gen_down_counter.sv
// Loadable down counter with a zero flag; load wins over decrement and it never wraps below 0.
module down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/en_pulse_gen.sv
// Programmable enable-strobe generator: en every div+1 clocks, for burst pulses or forever.
module en_pulse_gen
  import en_pulse_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             en,
  output logic             busy,
  output logic             done
);
  state_e             state_q, state_d;
  logic               en_q, en_d, done_q, done_d, cont_q, cont_d;
  logic [DIV_W-1:0]   div_q, div_d, per_val;
  logic               per_load, per_dec, per_zero;
  logic               pul_load, pul_dec, pul_zero;
  logic [DIV_W-1:0]   per_cnt_unused;
  logic [CNT_W-1:0]   pul_cnt;

  down_counter #(.W(DIV_W)) u_period (
    .clk(clk), .rst_n(reset), .load(per_load), .load_val(per_val), .dec(per_dec),
    .cnt(per_cnt_unused), .zero(per_zero)
  );

  down_counter #(.W(CNT_W)) u_pulses (
    .clk(clk), .rst_n(reset), .load(pul_load), .load_val(burst), .dec(pul_dec),
    .cnt(pul_cnt), .zero(pul_zero)
  );

  always_comb begin
    state_d  = state_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    cont_d   = cont_q;
    div_d    = div_q;
    per_load = 1'b0;
    per_val  = div_q;
    per_dec  = 1'b0;
    pul_load = 1'b0;
    pul_dec  = 1'b0;
    case (state_q)
      IDLE: if (start && !stop) begin
        per_load = 1'b1;
        per_val  = div;
        pul_load = 1'b1;
        div_d    = div;
        cont_d   = (burst == '0);
        state_d  = RUN;
      end
      RUN: if (stop) begin
        state_d = IDLE;
      end else if (per_zero) begin
        en_d     = 1'b1;
        per_load = 1'b1;
        // continuous mode leaves the pulse counter parked
        if (!cont_q && !pul_zero) begin
          pul_dec = 1'b1;
          if (pul_cnt == CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = LAST;
          end
        end
      end else begin
        per_dec = 1'b1;
      end
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      cont_q  <= 1'b0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      done_q  <= done_d;
      cont_q  <= cont_d;
      div_q   <= div_d;
    end
  end

  assign en   = en_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_en_pulse_gen.sv
// Scoreboard bench: stimulus queues expected en/done cycles, a negedge monitor pops and compares.
module tb_en_pulse_gen;
  localparam int DW = 8;
  localparam int CW = 8;

  typedef struct { int cyc; int done; } exp_t;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
  logic [DW-1:0] div = '0;
  logic [CW-1:0] burst = '0;
  logic          en, busy, done;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   e0;

  en_pulse_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .div(div), .burst(burst), .en(en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Any en or done is matched against the next expected pulse.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (en || done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_cycle", cyc, -1);
      end else begin
        e = exp_q.pop_front();
        check("en_cycle", cyc, e.cyc);
        check("en_high", int'(en), 1);
        check("done_with_en", int'(done), e.done);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_at(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic run_start(input int d, input int b, input int npulses, output int edge0);
    div   = DW'(d);
    burst = CW'(b);
    start = 1'b1;
    edge0 = cyc + 1;
    tick(1);
    start = 1'b0;
    for (int k = 1; k <= npulses; k++)
      exp_q.push_back(exp_t'{edge0 + k * (d + 1), (b != 0 && k == b) ? 1 : 0});
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      tick(1);
      guard++;
    end
    check({name, "_pending_pulses"}, exp_q.size(), 0);
    exp_q.delete();
    tick(2);
    check({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // reset held with start asserted
    div = 8'd2; burst = 8'd3; start = 1'b1;
    tick(3);
    check("rst_en", int'(en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    start = 1'b0;
    reset = 1'b1;
    tick(3);
    check("post_rst_busy", int'(busy), 0);

    // basic burst: div=2, burst=3
    run_start(2, 3, 3, e0);
    check("basic_busy_rise", int'(busy), 1);
    wait_at(e0 + 9);
    check("basic_busy_last_en", int'(busy), 1);
    wait_at(e0 + 10);
    check("basic_busy_fall", int'(busy), 0);
    check("basic_en_after", int'(en), 0);
    drain("basic");

    // continuous at div=0, stop at E20
    run_start(0, 0, 19, e0);
    wait_at(e0 + 19);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("cont_stop_en", int'(en), 0);
    check("cont_stop_done", int'(done), 0);
    check("cont_stop_busy", int'(busy), 0);
    drain("cont");

    // stop on the edge where the first pulse is due
    run_start(2, 3, 0, e0);
    wait_at(e0 + 2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_due_en", int'(en), 0);
    check("stop_due_busy", int'(busy), 0);
    drain("stop_due");

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("start_stop_busy", int'(busy), 0);
    tick(3);
    check("start_stop_busy_later", int'(busy), 0);

    // start during RUN with new div/burst is ignored
    run_start(2, 3, 3, e0);
    div = 8'd5; burst = 8'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    drain("start_in_run");

    // async reset mid-run after pulse 4, then single-pulse burst
    run_start(3, 10, 4, e0);
    wait_at(e0 + 17);
    #2 reset = 1'b0;
    #1;
    check("midrst_en", int'(en), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_pulses_seen", exp_q.size(), 0);
    exp_q.delete();
    tick(2);
    reset = 1'b1;
    tick(2);
    check("midrst_idle_after", int'(busy), 0);
    run_start(3, 1, 1, e0);
    drain("single");

    // wide divider: 256-cycle period
    run_start(255, 2, 2, e0);
    drain("wide");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/en_pulse_gen.md
# en_pulse_gen

Programmable enable-strobe generator that drives the `en` input of the synchronous-enable D flip-flop and register stages downstream. On `start`, it emits single-cycle `en` pulses with a period of `div+1` clocks. It emits either `burst` pulses and then stops, or runs continuously when `burst = 0`. It reports `busy` and a one-cycle `done` strobe at burst completion.

## Interface
- `DIV_W`, default 8: width of the period divider.
- `CNT_W`, default 8: width of the burst pulse count.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low (asserted when 0); clears all state immediately.
- `start` input, 1 bit: request to begin a run; sampled only in IDLE.
- `stop` input, 1 bit: synchronous abort of a run in progress.
- `div` input, DIV_W bits: period minus one; latched on an accepted `start`.
- `burst` input, CNT_W bits: number of pulses to emit; 0 means continuous; latched on an accepted `start`.
- `en` output, 1 bit: registered single-cycle enable pulse.
- `busy` output, 1 bit: high whenever the state is not IDLE.
- `done` output, 1 bit: registered single-cycle pulse, coincident with the final `en` of a finite burst.

## Operation
- States: IDLE, RUN, LAST.
- IDLE, `start`=1 and `stop`=0 at an edge:
  - load period counter with `div`;
  - load pulse counter with `burst`, and latch whether `burst` is 0;
  - go to RUN.
- RUN, each edge:
  - If `stop`=1: go to IDLE. `en` stays 0 at that edge and no `done` is issued. `stop` overrides a pending pulse.
  - Else if period counter = 0:
    - assert `en` for the next cycle;
    - reload the period counter with the latched `div`;
    - in finite mode, decrement the pulse counter.
    - If this is the final pulse (pulse counter = 1, finite mode): also assert `done` and go to LAST.
  - Else: decrement the period counter.
- LAST: go to IDLE unconditionally at the next edge. `stop` has no effect.
- `start` while `busy` is ignored; it is not queued.
- `start`=1 and `stop`=1 together in IDLE: remain in IDLE.
- Changes to `div` or `burst` during RUN have no effect until the next accepted `start`.
- Continuous mode runs until `stop` or `reset`. The pulse counter is not used and never wraps.
- Period counter: unsigned, DIV_W bits, no wrap (it is reloaded at 0). `div` = all-ones gives a period of 2^DIV_W.

## Timing
- Reset values: `en`=0, `busy`=0, `done`=0, state IDLE, both counters 0.
- Reset asserted mid-run clears all outputs asynchronously, without waiting for a clock edge. After deassertion, the block stays in IDLE until a new `start`.
- Latency: with `start` accepted at edge E0, the first `en` is high in the cycle after edge E0+div+1.
- `en` period: exactly `div+1` cycles; with `div`=0, `en` is high every cycle.
- `busy` rises in the cycle after edge E0. It stays high through the cycle of the final `en` and falls one cycle later (the LAST state).
- A new `start` can be accepted on the first edge after `busy` falls.
- `en` and `done` are always exactly one cycle wide and glitch-free (register outputs).

## Structure
- Shared package `en_pulse_pkg`:
  - state enum `{IDLE, RUN, LAST}`;
  - default `DIV_W`/`CNT_W` constants.
- Sub-module `down_counter`:
  - parameterised width, with load, decrement-enable and zero flag;
  - instantiated twice, once for the period and once for the pulse count.
- Top level holds the FSM and the output registers.

## Test plan
- **Reset:** hold `reset`=0 with `start`=1 → `en`/`busy`/`done` = 0. Release reset → still idle.
- **Basic burst:** `div`=2, `burst`=3, `start` pulse at E0 → `en` high in the cycles after E3, E6 and E9. `done` high with the third `en`. `busy` falls after E10.
- **Continuous:** `div`=0, `burst`=0 → `en` high every cycle from E1. `stop` at E20 → `en` low from the cycle after E20, no `done`.
- **Simultaneous events:**
  - `stop` on the same edge a pulse is due → no `en`.
  - `start` and `stop` together in IDLE → stays idle.
  - `start` during RUN with `div`=5 → ignored; original period kept.
- **Reset mid-run:** `div`=3, `burst`=10; drop `reset` between clock edges after pulse 4 → outputs 0 immediately. New `start` with `burst`=1 → exactly one `en` coincident with `done`.
- **Wide divider:** `div`=255, `burst`=2 → pulses exactly 256 cycles apart, with no counter wrap artefacts.
